// File: rtl/match_collector_if.sv
// Stream bundle between the comparator, the match collector and the host writer.
// Comparator signals flow in; buffered {A_idx, B_idx} pairs flow out.
interface match_collector_if #(
  parameter int unsigned ID_WIDTH = 16
);
  logic                    i_Match;
  logic                    i_Valid;
  logic                    i_Last;
  logic                    i_Ready;
  logic [2*ID_WIDTH-1:0]   o_Data;
  logic                    o_Valid;

  modport master (
    output i_Match, i_Valid, i_Last, i_Ready,
    input  o_Data, o_Valid
  );

  modport slave (
    input  i_Match, i_Valid, i_Last, i_Ready,
    output o_Data, o_Valid
  );
endinterface

// File: rtl/match_collector.sv
// Collects (A,B) index pairs of matching comparator beats into a FWFT FIFO
// and runs a per-run control FSM: count rows, drain, report completion.
module match_collector #(
  parameter int unsigned ID_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MCNT_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_Start,
  input  logic [ID_WIDTH-1:0]         i_NumA,
  match_collector_if.slave            io_stream,
  output logic                        o_Busy,
  output logic                        o_Done,
  output logic                        o_Overflow,
  output logic [MCNT_WIDTH-1:0]       o_MatchCount,
  output logic [$clog2(FIFO_DEPTH):0] o_Level
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned DATA_W = 2 * ID_WIDTH;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ID_WIDTH-1:0] r_a_idx;
  logic [ID_WIDTH-1:0] r_b_idx;
  logic [ID_WIDTH-1:0] r_num_a_m1;
  logic                r_overflow;
  logic [MCNT_WIDTH-1:0] r_mcount;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;

  logic                w_start;
  logic                w_beat;
  logic                w_not_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push_req;
  logic                w_push;
  logic                w_drop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and run-phase qualifiers
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          w_start     = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_beat = io_stream.i_Valid;
        if (io_stream.i_Valid && io_stream.i_Last && (r_a_idx == r_num_a_m1))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!w_not_empty) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle
  assign w_not_empty = (r_level != '0);
  assign w_full      = (r_level == FULL_LVL);
  assign w_pop       = w_not_empty & io_stream.i_Ready;
  assign w_push_req  = w_beat & io_stream.i_Match;
  assign w_push      = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop;

  // Pair index counters; a NumA of 0 runs as a single row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_idx    <= '0;
      r_b_idx    <= '0;
      r_num_a_m1 <= '0;
    end else if (w_start) begin
      r_a_idx    <= '0;
      r_b_idx    <= '0;
      r_num_a_m1 <= (i_NumA == '0) ? '0 : i_NumA - ID_WIDTH'(1);
    end else if (w_beat) begin
      if (io_stream.i_Last) begin
        r_b_idx <= '0;
        r_a_idx <= r_a_idx + ID_WIDTH'(1);
      end else begin
        r_b_idx <= r_b_idx + ID_WIDTH'(1);
      end
    end
  end

  // Run status: sticky overflow and saturating match count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_mcount   <= '0;
    end else if (w_start) begin
      r_overflow <= 1'b0;
      r_mcount   <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_push_req && (r_mcount != '1)) r_mcount <= r_mcount + MCNT_WIDTH'(1);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  // FIFO storage; contents are only visible through the level-qualified head
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_a_idx, r_b_idx};
  end

  assign io_stream.o_Valid = w_not_empty;
  assign io_stream.o_Data  = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign o_Busy            = (r_state != S_IDLE);
  assign o_Done            = (r_state == S_DONE);
  assign o_Overflow        = r_overflow;
  assign o_MatchCount      = r_mcount;
  assign o_Level           = r_level;

endmodule

// File: tb/tb_match_collector.sv
// Directed bench for match_collector: one task per scenario with inline checks.
module tb_match_collector;

  localparam int unsigned ID_W   = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned MCNT_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_Start;
  logic [ID_W-1:0]   i_NumA;
  logic              o_Busy;
  logic              o_Done;
  logic              o_Overflow;
  logic [MCNT_W-1:0] o_MatchCount;
  logic [4:0]        o_Level;

  match_collector_if #(.ID_WIDTH(ID_W)) bus ();

  match_collector #(
    .ID_WIDTH  (ID_W),
    .FIFO_DEPTH(DEPTH),
    .MCNT_WIDTH(MCNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_Start     (i_Start),
    .i_NumA      (i_NumA),
    .io_stream   (bus.slave),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Overflow  (o_Overflow),
    .o_MatchCount(o_MatchCount),
    .o_Level     (o_Level)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic [31:0] popped[$];

  // Advance one clock; record any pop about to happen and any done pulse seen.
  task automatic tick();
    if (bus.o_Valid && bus.i_Ready) popped.push_back(bus.o_Data);
    @(posedge clk);
    #1;
    if (o_Done) n_done++;
  endtask

  task automatic start_run(input logic [ID_W-1:0] num);
    popped.delete();
    n_done  = 0;
    i_NumA  = num;
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic beat(input logic m, input logic l);
    bus.i_Valid = 1'b1;
    bus.i_Match = m;
    bus.i_Last  = l;
    tick();
    bus.i_Valid = 1'b0;
    bus.i_Match = 1'b0;
    bus.i_Last  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    int n = 0;
    while (o_Busy && n < max_cycles) begin
      tick();
      n++;
    end
    ok = !o_Busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_Start = 1'b0; i_NumA = '0;
    bus.i_Valid = 1'b0; bus.i_Match = 1'b0; bus.i_Last = 1'b0; bus.i_Ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.o_Valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", bus.o_Valid); end
    n_cmp++; if (bus.o_Data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", bus.o_Data); end
    n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", o_Busy); end
    n_cmp++; if (o_Done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", o_Done); end
    n_cmp++; if (o_Level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d expected 0", o_Level); end
    n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow: got %b expected 0", o_Overflow); end
    n_cmp++; if (o_MatchCount !== 32'd0) begin n_err++; $display("FAIL rst_mcount: got %0d expected 0", o_MatchCount); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit          ok;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    bus.i_Ready = 1'b1;
    start_run(16'd2);
    n_cmp++; if (o_Busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", o_Busy); end
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++)
        beat((a == 0 && b == 1) || (a == 1 && b == 2), b == 2);
    wait_idle(50, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: busy %b expected 0", o_Busy); end
    exp_q = '{32'h0000_0001, 32'h0001_0002};
    n_cmp++; if (popped.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count: got %0d expected %0d", popped.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < popped.size()) ? popped[i] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== exp_q[i]) begin n_err++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got, exp_q[i]); end
    end
    n_cmp++; if (o_MatchCount !== 32'd2) begin n_err++; $display("FAIL basic_mcount: got %0d expected 2", o_MatchCount); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL basic_done: got %0d pulses expected 1", n_done); end
    n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL basic_overflow: got %b expected 0", o_Overflow); end
  endtask

  task automatic test_overflow();
    bit          ok;
    logic [31:0] got;
    bus.i_Ready = 1'b0;
    start_run(16'd1);
    for (int k = 0; k < 20; k++) beat(1'b1, k == 19);
    n_cmp++; if (o_Level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d expected 16", o_Level); end
    n_cmp++; if (o_Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", o_Overflow); end
    n_cmp++; if (o_MatchCount !== 32'd20) begin n_err++; $display("FAIL ovf_mcount: got %0d expected 20", o_MatchCount); end
    repeat (3) tick();
    n_cmp++; if (o_Busy !== 1'b1 || n_done != 0) begin n_err++; $display("FAIL ovf_hold: busy %b done %0d expected busy 1 done 0", o_Busy, n_done); end
    bus.i_Ready = 1'b1;
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL ovf_timeout: busy %b expected 0", o_Busy); end
    n_cmp++; if (popped.size() != 16) begin n_err++; $display("FAIL ovf_count: got %0d expected 16", popped.size()); end
    for (int b = 0; b < 16; b++) begin
      got = (b < popped.size()) ? popped[b] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== {16'd0, 16'(b)}) begin n_err++; $display("FAIL ovf_data[%0d]: got %h expected %h", b, got, {16'd0, 16'(b)}); end
    end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL ovf_done: got %0d pulses expected 1", n_done); end
  endtask

  task automatic test_full_pop();
    bit          ok;
    logic [31:0] got;
    bus.i_Ready = 1'b0;
    start_run(16'd1);
    for (int k = 0; k < 16; k++) beat(1'b1, 1'b0);
    n_cmp++; if (o_Level !== 5'd16 || o_Overflow !== 1'b0) begin n_err++; $display("FAIL fp_fill: level %0d ovf %b expected 16/0", o_Level, o_Overflow); end
    bus.i_Ready = 1'b1;
    beat(1'b1, 1'b1);
    n_cmp++; if (o_Level !== 5'd16) begin n_err++; $display("FAIL fp_level: got %0d expected 16", o_Level); end
    n_cmp++; if (o_Overflow !== 1'b0) begin n_err++; $display("FAIL fp_overflow: got %b expected 0", o_Overflow); end
    n_cmp++; if (o_MatchCount !== 32'd17) begin n_err++; $display("FAIL fp_mcount: got %0d expected 17", o_MatchCount); end
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL fp_timeout: busy %b expected 0", o_Busy); end
    n_cmp++; if (popped.size() != 17) begin n_err++; $display("FAIL fp_count: got %0d expected 17", popped.size()); end
    for (int b = 0; b < 17; b++) begin
      got = (b < popped.size()) ? popped[b] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== {16'd0, 16'(b)}) begin n_err++; $display("FAIL fp_data[%0d]: got %h expected %h", b, got, {16'd0, 16'(b)}); end
    end
  endtask

  task automatic test_back_to_back();
    bit          ok;
    bit          stalled;
    logic [31:0] held;
    logic [31:0] got;
    start_run(16'd1);
    for (int k = 0; k < 10; k++) begin
      bus.i_Ready = (k % 2 == 0);
      stalled = bus.o_Valid && !bus.i_Ready;
      held    = bus.o_Data;
      beat(1'b1, k == 9);
      if (stalled) begin
        n_cmp++; if (bus.o_Data !== held) begin n_err++; $display("FAIL bp_stable[%0d]: got %h expected %h", k, bus.o_Data, held); end
      end
    end
    bus.i_Ready = 1'b1;
    wait_idle(100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: busy %b expected 0", o_Busy); end
    n_cmp++; if (popped.size() != 10) begin n_err++; $display("FAIL bp_count: got %0d expected 10", popped.size()); end
    for (int b = 0; b < 10; b++) begin
      got = (b < popped.size()) ? popped[b] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== {16'd0, 16'(b)}) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected %h", b, got, {16'd0, 16'(b)}); end
    end
  endtask

  task automatic test_ignored();
    bit          ok;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    bus.i_Ready = 1'b1;
    bus.i_Valid = 1'b1; bus.i_Match = 1'b1; bus.i_Last = 1'b1;
    repeat (3) tick();
    bus.i_Valid = 1'b0; bus.i_Match = 1'b0; bus.i_Last = 1'b0;
    n_cmp++; if (o_Level !== 5'd0 || bus.o_Valid !== 1'b0) begin n_err++; $display("FAIL idle_push: level %0d valid %b expected 0/0", o_Level, bus.o_Valid); end
    n_cmp++; if (o_MatchCount !== 32'd10) begin n_err++; $display("FAIL idle_mcount: got %0d expected 10", o_MatchCount); end
    n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", o_Busy); end
    start_run(16'd1);
    beat(1'b1, 1'b0);
    i_NumA  = 16'd5;
    i_Start = 1'b1;
    beat(1'b0, 1'b0);
    i_Start = 1'b0;
    beat(1'b1, 1'b1);
    wait_idle(50, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL restart_timeout: busy %b expected 0", o_Busy); end
    exp_q = '{32'h0000_0000, 32'h0000_0002};
    n_cmp++; if (popped.size() != exp_q.size()) begin n_err++; $display("FAIL restart_count: got %0d expected %0d", popped.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < popped.size()) ? popped[i] : 32'hxxxx_xxxx;
      n_cmp++; if (got !== exp_q[i]) begin n_err++; $display("FAIL restart_data[%0d]: got %h expected %h", i, got, exp_q[i]); end
    end
    n_cmp++; if (o_MatchCount !== 32'd2) begin n_err++; $display("FAIL restart_mcount: got %0d expected 2", o_MatchCount); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL restart_done: got %0d pulses expected 1", n_done); end
  endtask

  task automatic test_reset_midrun();
    bit          ok;
    logic [31:0] got;
    bus.i_Ready = 1'b0;
    start_run(16'd3);
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0);
    n_cmp++; if (o_Level !== 5'd5) begin n_err++; $display("FAIL mr_level_pre: got %0d expected 5", o_Level); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_Valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b expected 0", bus.o_Valid); end
    n_cmp++; if (o_Level !== 5'd0) begin n_err++; $display("FAIL mr_level: got %0d expected 0", o_Level); end
    n_cmp++; if (o_Busy !== 1'b0) begin n_err++; $display("FAIL mr_busy: got %b expected 0", o_Busy); end
    n_cmp++; if (o_MatchCount !== 32'd0) begin n_err++; $display("FAIL mr_mcount: got %0d expected 0", o_MatchCount); end
    tick();
    tick();
    n_cmp++; if (n_done != 0) begin n_err++; $display("FAIL mr_done: got %0d pulses expected 0", n_done); end
    rst = 1'b0;
    bus.i_Ready = 1'b1;
    start_run(16'd1);
    beat(1'b1, 1'b1);
    wait_idle(50, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL mr_timeout: busy %b expected 0", o_Busy); end
    got = (popped.size() > 0) ? popped[0] : 32'hxxxx_xxxx;
    n_cmp++; if (popped.size() != 1 || got !== 32'h0) begin n_err++; $display("FAIL mr_restart: got %0d entries head %h expected 1 entry 00000000", popped.size(), got); end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL mr_restart_done: got %0d pulses expected 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_ignored();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
